// File: rtl/usb_tx_arbiter.sv
// Transmit-path arbiter in front of the ULPI packet encoder: serves handshakes first,
// then locks one end-point onto the encoder for a whole DATAx packet.
module usb_tx_arbiter #(
   parameter int MAX_PACKET    = 512,
   parameter int START_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mux_enable_i,
   input  logic [4:0]  ep_select_i,
   input  logic        hsk_send_i,
   input  logic [3:0]  hsk_pid_i,
   output logic        hsk_sent_o,
   output logic        enc_hsk_send_o,
   output logic [3:0]  enc_hsk_pid_o,
   input  logic        enc_hsk_sent_i,
   input  logic [4:0]  ep_tvalid_i,
   output logic [4:0]  ep_tready_o,
   input  logic [4:0]  ep_tlast_i,
   input  logic [39:0] ep_tdata_i,
   input  logic [4:0]  ep_parity_i,
   output logic        enc_tvalid_o,
   input  logic        enc_tready_i,
   output logic        enc_tlast_o,
   output logic [7:0]  enc_tdata_o,
   output logic [3:0]  enc_tuser_o,
   output logic        usb_sent_o,
   output logic        timeout_o,
   output logic        overflow_o,
   output logic        busy_o
);

   localparam int CW = $clog2(MAX_PACKET) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PACKET - 1);
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HSK   = 2'd1,
      DATA  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t          state_r;
   logic [2:0]      sel_r;
   logic [CW-1:0]   count_r;
   logic [7:0]      timer_r;
   logic            started_r;
   logic [3:0]      hsk_pid_r;
   logic [3:0]      tuser_r;
   logic            hsk_sent_r;
   logic            enc_hsk_send_r;
   logic            usb_sent_r;
   logic            timeout_r;
   logic            overflow_r;
   logic            busy_r;

   logic [2:0]      sel_idx_s;
   logic            onehot_s;
   logic            src_valid_s;
   logic            src_last_s;
   logic [7:0]      src_data_s;
   logic            at_limit_s;
   logic            data_pass_s;
   logic            beat_s;

   // Decode the one-hot end-point select; anything else is not a valid request
   always_comb begin
      sel_idx_s = 3'd0;
      onehot_s  = 1'b1;
      case (ep_select_i)
         5'b00001: sel_idx_s = 3'd0;
         5'b00010: sel_idx_s = 3'd1;
         5'b00100: sel_idx_s = 3'd2;
         5'b01000: sel_idx_s = 3'd3;
         5'b10000: sel_idx_s = 3'd4;
         default:  onehot_s  = 1'b0;
      endcase
   end

   assign src_valid_s = ep_tvalid_i[sel_r];
   assign src_last_s  = ep_tlast_i[sel_r];
   assign src_data_s  = ep_tdata_i[{sel_r, 3'b000} +: 8];
   assign at_limit_s  = (count_r == LAST_IDX);
   assign data_pass_s = (state_r == DATA) && mux_enable_i;
   assign beat_s      = data_pass_s && src_valid_s && enc_tready_i;

   // Zero-latency byte path; losing mux_enable cuts the path in the same cycle
   always_comb begin
      enc_tvalid_o = 1'b0;
      enc_tdata_o  = 8'd0;
      enc_tlast_o  = 1'b0;
      ep_tready_o  = 5'd0;
      if (data_pass_s) begin
         enc_tvalid_o        = src_valid_s;
         enc_tdata_o         = src_data_s;
         enc_tlast_o         = src_last_s | at_limit_s;
         ep_tready_o[sel_r]  = enc_tready_i;
      end else if (state_r == FLUSH) begin
         ep_tready_o[sel_r]  = 1'b1;
      end else begin
         ep_tready_o         = 5'd0;
      end
   end

   // Arbitration FSM with registered status pulses
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r        <= IDLE;
         sel_r          <= 3'd0;
         count_r        <= '0;
         timer_r        <= 8'd0;
         started_r      <= 1'b0;
         hsk_pid_r      <= 4'd0;
         tuser_r        <= 4'd0;
         hsk_sent_r     <= 1'b0;
         enc_hsk_send_r <= 1'b0;
         usb_sent_r     <= 1'b0;
         timeout_r      <= 1'b0;
         overflow_r     <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         hsk_sent_r <= 1'b0;
         usb_sent_r <= 1'b0;
         timeout_r  <= 1'b0;
         overflow_r <= 1'b0;
         case (state_r)
            IDLE: begin
               // The requester still holds hsk_send during the sent pulse; skip that cycle
               if (hsk_send_i && !hsk_sent_r) begin
                  hsk_pid_r      <= hsk_pid_i;
                  enc_hsk_send_r <= 1'b1;
                  state_r        <= HSK;
                  busy_r         <= 1'b1;
               end else if (mux_enable_i && onehot_s) begin
                  sel_r     <= sel_idx_s;
                  tuser_r   <= ep_parity_i[sel_idx_s] ? PID_DATA1 : PID_DATA0;
                  count_r   <= '0;
                  timer_r   <= 8'(START_TIMEOUT);
                  started_r <= 1'b0;
                  state_r   <= DATA;
                  busy_r    <= 1'b1;
               end else begin
                  busy_r    <= 1'b0;
               end
            end
            HSK: begin
               if (enc_hsk_sent_i) begin
                  hsk_sent_r     <= 1'b1;
                  enc_hsk_send_r <= 1'b0;
                  state_r        <= IDLE;
                  busy_r         <= 1'b0;
               end
            end
            DATA: begin
               if (!mux_enable_i) begin
                  state_r <= started_r ? FLUSH : IDLE;
                  busy_r  <= started_r;
               end else if (beat_s) begin
                  started_r <= 1'b1;
                  if (src_last_s) begin
                     usb_sent_r <= 1'b1;
                     state_r    <= IDLE;
                     busy_r     <= 1'b0;
                  end else if (at_limit_s) begin
                     usb_sent_r <= 1'b1;
                     overflow_r <= 1'b1;
                     state_r    <= FLUSH;
                  end else begin
                     count_r    <= count_r + {{(CW-1){1'b0}}, 1'b1};
                  end
               end else if (!started_r) begin
                  timer_r <= timer_r - 8'd1;
                  if (timer_r <= 8'd1) begin
                     timeout_r <= 1'b1;
                     state_r   <= IDLE;
                     busy_r    <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (src_valid_s && src_last_s) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign hsk_sent_o     = hsk_sent_r;
   assign enc_hsk_send_o = enc_hsk_send_r;
   assign enc_hsk_pid_o  = hsk_pid_r;
   assign enc_tuser_o    = tuser_r;
   assign usb_sent_o     = usb_sent_r;
   assign timeout_o      = timeout_r;
   assign overflow_o     = overflow_r;
   assign busy_o         = busy_r;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed-plus-random bench for usb_tx_arbiter; packet outcomes come from a
// byte-count model (truncation at MAX_PACKET, flush after a dropped grant).
module tb_usb_tx_arbiter;

   localparam int MAXP = 512;
   localparam int STO  = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        mux_enable_i;
   logic [4:0]  ep_select_i;
   logic        hsk_send_i;
   logic [3:0]  hsk_pid_i;
   logic        hsk_sent_o;
   logic        enc_hsk_send_o;
   logic [3:0]  enc_hsk_pid_o;
   logic        enc_hsk_sent_i;
   logic [4:0]  ep_tvalid_i;
   logic [4:0]  ep_tready_o;
   logic [4:0]  ep_tlast_i;
   logic [39:0] ep_tdata_i;
   logic [4:0]  ep_parity_i;
   logic        enc_tvalid_o;
   logic        enc_tready_i;
   logic        enc_tlast_o;
   logic [7:0]  enc_tdata_o;
   logic [3:0]  enc_tuser_o;
   logic        usb_sent_o;
   logic        timeout_o;
   logic        overflow_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   logic [7:0] data [0:1023];

   always #5 clock = ~clock;

   usb_tx_arbiter #(.MAX_PACKET(MAXP), .START_TIMEOUT(STO)) dut (
      .clock(clock), .reset(reset), .mux_enable_i(mux_enable_i), .ep_select_i(ep_select_i),
      .hsk_send_i(hsk_send_i), .hsk_pid_i(hsk_pid_i), .hsk_sent_o(hsk_sent_o),
      .enc_hsk_send_o(enc_hsk_send_o), .enc_hsk_pid_o(enc_hsk_pid_o), .enc_hsk_sent_i(enc_hsk_sent_i),
      .ep_tvalid_i(ep_tvalid_i), .ep_tready_o(ep_tready_o), .ep_tlast_i(ep_tlast_i),
      .ep_tdata_i(ep_tdata_i), .ep_parity_i(ep_parity_i), .enc_tvalid_o(enc_tvalid_o),
      .enc_tready_i(enc_tready_i), .enc_tlast_o(enc_tlast_o), .enc_tdata_o(enc_tdata_o),
      .enc_tuser_o(enc_tuser_o), .usb_sent_o(usb_sent_o), .timeout_o(timeout_o),
      .overflow_o(overflow_o), .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [28:0] all_outputs();
      return {hsk_sent_o, enc_hsk_send_o, enc_hsk_pid_o, ep_tready_o, enc_tvalid_o, enc_tlast_o,
              enc_tdata_o, enc_tuser_o, usb_sent_o, timeout_o, overflow_o, busy_o};
   endfunction

   // Stream n bytes from end-point ep; drop_after >= 1 removes mux_enable after that many encoder beats
   task automatic run_packet(input int ep, input bit par, input int n, input int drop_after, input string tag);
      int src_idx = 0, enc_cnt = 0, flushed = 0, tlast_beats = 0;
      int bad_data = 0, bad_iso = 0, sent = 0, ovf = 0, tmo = 0, cycles = 0, post = 0;
      int exp_len;
      bit dropped;
      dropped = (drop_after >= 1);
      exp_len = dropped ? drop_after : ((n < MAXP) ? n : MAXP);
      @(negedge clock);
      ep_select_i  = 5'(1 << ep);
      mux_enable_i = 1'b1;
      ep_parity_i  = 5'($urandom);
      ep_parity_i[ep] = par;
      ep_tvalid_i  = 5'd0;
      while (post < 4 && cycles < 5000) begin
         @(negedge clock);
         cycles++;
         sent += int'(usb_sent_o);
         ovf  += int'(overflow_o);
         tmo  += int'(timeout_o);
         if (dropped && enc_cnt == drop_after) mux_enable_i = 1'b0;
         if (src_idx >= n) begin
            mux_enable_i = 1'b0;
            post++;
         end
         ep_tvalid_i = 5'($urandom);
         ep_tlast_i  = 5'($urandom);
         ep_tdata_i  = {8'($urandom), 32'($urandom)};
         if (src_idx < n) begin
            ep_tvalid_i[ep]        = ($urandom_range(3, 0) != 0);
            ep_tdata_i[ep*8 +: 8]  = data[src_idx];
            ep_tlast_i[ep]         = (src_idx == n - 1);
         end else begin
            ep_tvalid_i[ep]        = 1'b0;
         end
         enc_tready_i = ($urandom_range(3, 0) != 0);
         #1;
         if ((ep_tready_o & ~5'(1 << ep)) != 5'd0) bad_iso++;
         if (!mux_enable_i && enc_tvalid_o) bad_iso++;
         if (ep_tvalid_i[ep] && ep_tready_o[ep]) begin
            if (enc_tvalid_o && enc_tready_i) begin
               if (enc_cnt >= exp_len || enc_tdata_o !== data[enc_cnt]) bad_data++;
               if (enc_tlast_o) begin
                  tlast_beats++;
                  if (enc_cnt != exp_len - 1) bad_data++;
               end
               enc_cnt++;
            end else begin
               flushed++;
            end
            src_idx++;
         end else if (enc_tvalid_o && enc_tready_i) begin
            bad_data++;
         end
      end
      check({tag, "_src_done"}, 64'(src_idx), 64'(n));
      check({tag, "_enc_bytes"}, 64'(enc_cnt), 64'(exp_len));
      check({tag, "_byte_order"}, 64'(bad_data), 64'd0);
      check({tag, "_tlast_cnt"}, 64'(tlast_beats), dropped ? 64'd0 : 64'd1);
      check({tag, "_isolation"}, 64'(bad_iso), 64'd0);
      check({tag, "_flushed"}, 64'(flushed), 64'(n - exp_len));
      check({tag, "_usb_sent"}, 64'(sent), dropped ? 64'd0 : 64'd1);
      check({tag, "_overflow"}, 64'(ovf), (!dropped && n > MAXP) ? 64'd1 : 64'd0);
      check({tag, "_timeout"}, 64'(tmo), 64'd0);
      check({tag, "_tuser"}, 64'(enc_tuser_o), par ? 64'hB : 64'h3);
      check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
      ep_tvalid_i = 5'd0;
      ep_select_i = 5'd0;
   endtask

   // Request a handshake, let the encoder finish after delay cycles, expect exactly one sent pulse
   task automatic run_hsk(input logic [3:0] pid, input int delay, input string tag);
      int w = 0, bad = 0, pulses = 0;
      @(negedge clock);
      hsk_send_i = 1'b1;
      hsk_pid_i  = pid;
      while (!enc_hsk_send_o && w < 40) begin
         @(negedge clock);
         w++;
      end
      check({tag, "_granted"}, 64'(enc_hsk_send_o), 64'd1);
      check({tag, "_pid"}, 64'(enc_hsk_pid_o), 64'(pid));
      for (int i = 1; i < delay; i++) begin
         @(negedge clock);
         if (!enc_hsk_send_o) bad++;
      end
      enc_hsk_sent_i = 1'b1;
      @(negedge clock);
      enc_hsk_sent_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (hsk_sent_o) begin
            pulses++;
            hsk_send_i = 1'b0;
         end
         if (enc_hsk_send_o) bad++;
         @(negedge clock);
      end
      check({tag, "_sent_pulses"}, 64'(pulses), 64'd1);
      check({tag, "_send_level"}, 64'(bad), 64'd0);
      check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      int tmo_at, saw_valid, hsk_early, bad;
      reset = 1'b1;
      mux_enable_i = 1'b0; ep_select_i = 5'd0; hsk_send_i = 1'b0; hsk_pid_i = 4'd0;
      enc_hsk_sent_i = 1'b0; ep_tvalid_i = 5'd0; ep_tlast_i = 5'd0; ep_tdata_i = 40'd0;
      ep_parity_i = 5'd0; enc_tready_i = 1'b0;
      #12;
      check("reset_outputs", 64'(all_outputs()), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      run_hsk(4'b0010, 4, "hsk_ack");

      for (int i = 0; i < 1024; i++) data[i] = 8'(i);
      run_packet(2, 1'b1, 8, 0, "ep2_8b");
      run_packet(1, 1'b0, MAXP, 0, "exact_max");
      run_packet(4, 1'b1, MAXP + 8, 0, "overflow");

      // Start timeout with a handshake requested mid-way
      @(negedge clock);
      ep_select_i = 5'b00001; mux_enable_i = 1'b1; ep_tvalid_i = 5'd0; enc_tready_i = 1'b1;
      tmo_at = 0; saw_valid = 0; hsk_early = 0;
      for (int w = 1; w <= 40 && tmo_at == 0; w++) begin
         @(negedge clock);
         if (w == 3) begin
            hsk_send_i = 1'b1;
            hsk_pid_i  = 4'b1010;
         end
         #1;
         if (enc_tvalid_o) saw_valid++;
         if (enc_hsk_send_o) hsk_early++;
         if (timeout_o) tmo_at = w;
      end
      mux_enable_i = 1'b0; ep_select_i = 5'd0;
      check("tmo_cycle", 64'(tmo_at), 64'(STO + 1));
      check("tmo_no_valid", 64'(saw_valid), 64'd0);
      check("tmo_hsk_blocked", 64'(hsk_early), 64'd0);
      run_hsk(4'b1010, 2, "hsk_after_tmo");

      // Grant dropped before any byte moves
      @(negedge clock);
      ep_select_i = 5'b01000; mux_enable_i = 1'b1; ep_tvalid_i = 5'd0;
      @(negedge clock);
      check("early_drop_busy", 64'(busy_o), 64'd1);
      @(negedge clock);
      mux_enable_i = 1'b0;
      @(negedge clock);
      check("early_drop_idle", 64'({busy_o, usb_sent_o, timeout_o}), 64'd0);

      // Non one-hot selects grant nothing
      bad = 0;
      @(negedge clock);
      mux_enable_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ep_select_i = (i < 4) ? 5'b00011 : 5'b00000;
         ep_tvalid_i = 5'($urandom);
         enc_tready_i = 1'b1;
         @(negedge clock);
         #1;
         if (busy_o || ep_tready_o != 5'd0 || enc_tvalid_o) bad++;
      end
      mux_enable_i = 1'b0; ep_select_i = 5'd0; ep_tvalid_i = 5'd0;
      check("multi_select_idle", 64'(bad), 64'd0);

      run_packet(0, 1'b0, 10, 2, "drop_after2");

      for (int k = 0; k < 8; k++) begin
         int ep, n, drop;
         bit par;
         ep  = int'($urandom_range(4, 0));
         par = 1'($urandom);
         n   = int'($urandom_range(40, 1));
         drop = ($urandom_range(3, 0) == 0 && n > 1) ? int'($urandom_range(n - 1, 1)) : 0;
         for (int i = 0; i < n; i++) data[i] = 8'($urandom);
         run_packet(ep, par, n, drop, "rand");
      end

      // Asynchronous reset in the middle of a packet (three bytes already sent)
      for (int i = 0; i < 16; i++) data[i] = 8'(i);
      @(negedge clock);
      ep_select_i = 5'b00010; ep_parity_i = 5'b00010; mux_enable_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         ep_tvalid_i = 5'b00010; ep_tlast_i = 5'd0; ep_tdata_i = 40'd0;
         ep_tdata_i[15:8] = data[i]; enc_tready_i = 1'b1;
      end
      #1;
      check("pre_reset_valid", 64'({enc_tvalid_o, enc_tdata_o}), 64'h103);
      #1 reset = 1'b1;
      #1;
      check("async_reset_outputs", 64'(all_outputs()), 64'd0);
      @(negedge clock);
      mux_enable_i = 1'b0; ep_tvalid_i = 5'd0; ep_select_i = 5'd0;
      reset = 1'b0;
      @(negedge clock);
      check("post_reset_idle", 64'(busy_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
Shares the single ULPI packet-encoder transmit path between the handshake generator and the five transmit sources (EP0 control, EP1-EP4 bulk IN). The protocol FSM supplies the handshake requests, the mux-enable and the one-hot end-point select. This block grants the encoder, locks the grant for a whole packet, and generates the DATA0/DATA1 PID from the end-point parity. It also enforces a start-of-packet timeout and a maximum packet length, and reports completion back to the protocol FSM.

Parameters:
MAX_PACKET, 512, maximum DATAx payload bytes per packet (1..1024).
START_TIMEOUT, 16, clocks allowed between grant and the first accepted byte (1..255).

Ports:
clock  in  1  system clock (60 MHz ULPI domain)
reset  in  1  asynchronous, active-high reset
mux_enable_i  in  1  protocol FSM permits data transmission
ep_select_i  in  5  one-hot end-point select; bit n = EPn
hsk_send_i  in  1  level request to send a handshake; held until hsk_sent_o
hsk_pid_i  in  4  handshake PID (ACK/NAK/STALL/NYET)
hsk_sent_o  out  1  one-cycle pulse, handshake transmitted
enc_hsk_send_o  out  1  handshake request to encoder
enc_hsk_pid_o  out  4  handshake PID to encoder
enc_hsk_sent_i  in  1  encoder finished handshake
ep_tvalid_i  in  5  per-EP byte valid
ep_tready_o  out  5  per-EP byte ready
ep_tlast_i  in  5  per-EP last byte
ep_tdata_i  in  40  per-EP byte; EPn on bits [8n+7:8n]
ep_parity_i  in  5  per-EP DATAx toggle (0 = DATA0, 1 = DATA1)
enc_tvalid_o  out  1  byte valid to encoder
enc_tready_i  in  1  encoder accepts byte
enc_tlast_o  out  1  last byte to encoder
enc_tdata_o  out  8  byte to encoder
enc_tuser_o  out  4  DATAx PID for the current packet
usb_sent_o  out  1  one-cycle pulse, packet's last byte accepted by encoder
timeout_o  out  1  one-cycle pulse, start timeout expired
overflow_o  out  1  one-cycle pulse, MAX_PACKET truncation
busy_o  out  1  state != IDLE

Behaviour:
- Reset (asynchronous): state = IDLE, counters = 0, PID/select registers = 0. Every output is 0, including ep_tready_o = 5'b0.
- States: IDLE, HSK, DATA, FLUSH.
- Beat: a byte transfers on any cycle with tvalid && tready.

IDLE:
- Handshake takes priority. If hsk_send_i = 1, latch hsk_pid_i and go to HSK.
- Otherwise, if mux_enable_i = 1 and ep_select_i is exactly one-hot:
  - latch sel = index of the set bit;
  - latch enc_tuser_o = ep_parity_i[sel] ? 4'b1011 (DATA1) : 4'b0011 (DATA0);
  - clear the byte counter, load timer = START_TIMEOUT, go to DATA.
- If ep_select_i is zero or has multiple bits set, stay in IDLE and grant nothing.

HSK:
- enc_hsk_send_o = 1 and enc_hsk_pid_o = latched PID, both registered, starting the cycle after entry.
- On enc_hsk_sent_i: hsk_sent_o pulses for one cycle, enc_hsk_send_o falls, go to IDLE.
- Data requests are ignored while in HSK.

DATA (zero-latency combinational pass-through from ep[sel]):
- enc_tvalid_o = ep_tvalid_i[sel]; enc_tdata_o = ep_tdata_i[sel]; ep_tready_o[sel] = enc_tready_i. All other ep_tready_o bits = 0.
- enc_tlast_o = ep_tlast_i[sel] | (count == MAX_PACKET-1).
- The counter increments on each beat. Width is clog2(MAX_PACKET)+1; it never wraps because the packet terminates at MAX_PACKET-1.
- Timer:
  - decrements each cycle until the first beat;
  - is frozen once a beat has occurred;
  - on reaching 0 with no beat: timeout_o pulses, go to IDLE, no usb_sent_o.
- Beat with source tlast: usb_sent_o pulses, go to IDLE.
- Beat with forced tlast (count == MAX_PACKET-1 and source tlast = 0): usb_sent_o and overflow_o both pulse, go to FLUSH.
- mux_enable_i falls:
  - before the first beat: go to IDLE;
  - after the first beat: go to FLUSH, and drive enc_tvalid_o = 0 from that cycle.
- hsk_send_i asserted during DATA is held by the requester and serviced in IDLE afterwards.

FLUSH:
- ep_tready_o[sel] = 1 and enc_tvalid_o = 0; source bytes are discarded.
- On a source beat with tlast, go to IDLE.

Simultaneous events:
- Timer expiry and first beat in the same cycle: the beat wins and there is no timeout.
- Source tlast and count == MAX_PACKET-1 in the same cycle: normal completion, no overflow.

Other:
- enc_tuser_o holds its value from grant until the next grant.
- busy_o is registered from state.

Test Plan:
- Reset mid-packet (DATA, count = 3) -> all outputs 0 immediately (asynchronous), state IDLE after release.
- hsk_send_i = 1 with hsk_pid_i = 4'b0010 (ACK); encoder sent 4 cycles later -> enc_hsk_pid_o = 4'b0010, exactly one hsk_sent_o pulse, busy_o = 0 afterwards.
- ep_select_i = 5'b00100, mux_enable_i = 1, ep_parity_i[2] = 1; 8-byte packet 0x00..0x07 with random encoder backpressure -> enc_tuser_o = 4'b1011, bytes in order, enc_tlast_o on 0x07, one usb_sent_o pulse, ep_tready_o[1:0] and ep_tready_o[4:3] stay 0.
- EP0 selected with tvalid never asserted, START_TIMEOUT = 16 -> timeout_o pulses 16 cycles after grant, no enc_tvalid_o, return to IDLE; hsk_send_i raised concurrently is served afterwards.
- MAX_PACKET = 512, source streams 520 bytes with tlast on byte 519 -> enc_tlast_o on byte 511, overflow_o and usb_sent_o pulse; 8 bytes flushed with enc_tvalid_o = 0; IDLE after byte 519.
- ep_select_i = 5'b00011 -> no grant and busy_o stays 0; then mux_enable_i drops after 2 beats of a 10-byte packet -> FLUSH consumes the remaining 8 bytes, no usb_sent_o.
